// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared types, constants and grant encoder for rr_arb4_pol.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

  localparam int IDX_W = 2;
  localparam int N_REQ = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  // Grant vector for a given polarity: one-hot high when pol=1, one-cold
  // low when pol=0. With act=0 this yields the inactive pattern.
  function automatic logic [N_REQ-1:0] f_encode(input logic pol,
                                                input logic act,
                                                input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = act ? (N_REQ'(1) << idx) : '0;
    return pol ? oh : ~oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4_pol_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_pol_if
// Description : Request/grant bundle between agents and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arb4_pol_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             rel;
  logic             pol;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  // Agent side: raises requests, releases, chooses polarity.
  modport master (output req, rel, pol,
                  input  gnt, gnt_idx, gnt_vld, timeout);

  // Arbiter side.
  modport slave  (input  req, rel, pol,
                  output gnt, gnt_idx, gnt_vld, timeout);
endinterface
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin pick; scans ptr+1 .. ptr (mod 4).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import rr_arb_pkg::*;
(
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic      [IDX_W-1:0] win_idx,
  output logic                  win_vld
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    w_cand  = '0;
    win_idx = '0;
    win_vld = |req;
    for (int off = N_REQ; off >= 1; off--) begin
      w_cand = ptr + IDX_W'(off);
      if (req[w_cand]) win_idx = w_cand;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb4_pol.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_pol
// Description : 4-way round-robin arbiter with hold timeout and run-time
//               grant polarity (one-hot high or one-cold low).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4_pol
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter bit POL_RST  = 1'b1
)(
  input  wire logic   clk,
  input  wire logic   rst,
  rr_arb4_pol_if.slave bus
);

  localparam int                CNT_W      = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [N_REQ-1:0]  C_GNT_RST  = POL_RST ? {N_REQ{1'b0}} : {N_REQ{1'b1}};

  state_t           r_state,   w_state_nxt;
  logic [IDX_W-1:0] r_ptr,     w_ptr_nxt;
  logic             r_pol_q,   w_pol_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [N_REQ-1:0] r_gnt,     w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_idx_nxt;
  logic             r_gnt_vld, w_vld_nxt;
  logic             r_timeout, w_to_nxt;

  logic             w_act;
  logic             w_own_req;
  logic             w_limit;
  logic             w_exit;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

  assign w_own_req = bus.req[r_gnt_idx];
  assign w_limit   = (r_cnt == C_CNT_LAST);
  assign w_exit    = bus.rel | ~w_own_req | w_limit;

  // Next-state and registered-output decode; polarity follows pol while
  // idle and on the GAP->IDLE edge, and is frozen for the whole grant.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_pol_nxt   = r_pol_q;
    w_cnt_nxt   = '0;
    w_idx_nxt   = '0;
    w_vld_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    w_act       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pol_nxt = bus.pol;
        if (w_win_vld) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_win_idx;
          w_vld_nxt   = 1'b1;
          w_act       = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_exit) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = r_gnt_idx;
          // Only a pure limit exit counts as a timeout.
          w_to_nxt    = w_limit & ~bus.rel & w_own_req;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_idx_nxt = r_gnt_idx;
          w_vld_nxt = 1'b1;
          w_act     = 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
        w_pol_nxt   = bus.pol;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_gnt_nxt = f_encode(w_pol_nxt, w_act, w_idx_nxt);
  end

  // State and output registers with asynchronous reset to the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd3;
      r_pol_q   <= POL_RST;
      r_cnt     <= '0;
      r_gnt     <= C_GNT_RST;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_pol_q   <= w_pol_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_gnt_vld <= w_vld_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.timeout = r_timeout;

endmodule
`default_nettype wire
